// File: rtl/micro_tile_sched.sv
// Time-shares one 8-bit dedicated I/O slot among NUM_PROJ micro-tile projects.
// Every switch holds all project resets, enables the target, then releases its reset.
module micro_tile_sched #(
    parameter int NUM_PROJ   = 4,
    parameter int IDX_W      = 2,
    parameter int RST_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            ui_in,
    output logic [7:0]            uo_out,
    input  logic                  sel_valid,
    input  logic [IDX_W-1:0]      sel_idx,
    output logic                  sel_ready,
    output logic                  sel_err,
    input  logic [NUM_PROJ*8-1:0] proj_uo,
    output logic [NUM_PROJ-1:0]   proj_ena,
    output logic [NUM_PROJ-1:0]   proj_rst_n,
    output logic [IDX_W-1:0]      active_idx,
    output logic                  busy
);

    // state  | meaning
    // IDLE   | nothing selected, ui_in looped back to uo_out
    // HOLD   | all project resets low for RST_CYCLES cycles
    // ENABLE | target project enabled, still in reset
    // RUN    | target project enabled and out of reset, outputs routed

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(RST_CYCLES - 1);
    localparam logic [IDX_W:0]   NUM_PROJ_W = (IDX_W + 1)'(NUM_PROJ);

    typedef enum logic [1:0] {IDLE, HOLD, ENABLE, RUN} state_t;

    logic [1:0]          rst_sync_q;
    logic                rst_n_i;
    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [IDX_W-1:0]    active_idx_q;
    logic [NUM_PROJ-1:0] proj_ena_q;
    logic [NUM_PROJ-1:0] proj_rst_n_q;
    logic                sel_err_q;
    logic                accept;
    logic                idx_ok;
    logic [NUM_PROJ-1:0] active_onehot;

    // Assertion is immediate; release reaches the state flops two edges later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n_i = rst_sync_q[1];

    assign sel_ready     = rst_n_i && ((state_q == IDLE) || (state_q == RUN));
    assign accept        = sel_valid && sel_ready;
    assign idx_ok        = ({1'b0, sel_idx} < NUM_PROJ_W);
    assign active_onehot = NUM_PROJ'(1) << active_idx_q;

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            active_idx_q <= '0;
            proj_ena_q   <= '0;
            proj_rst_n_q <= '0;
            sel_err_q    <= 1'b0;
        end else if (accept && !idx_ok) begin
            sel_err_q <= 1'b1;
        end else if (accept) begin
            state_q      <= HOLD;
            active_idx_q <= sel_idx;
            sel_err_q    <= 1'b0;
            cnt_q        <= CNT_LOAD;
            proj_ena_q   <= '0;
            proj_rst_n_q <= '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q    <= ENABLE;
                        proj_ena_q <= active_onehot;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ENABLE: begin
                    state_q      <= RUN;
                    proj_rst_n_q <= active_onehot;
                end
                default: ;
            endcase
        end
    end

    assign uo_out     = (state_q == RUN) ? proj_uo[8*active_idx_q +: 8] : ui_in;
    assign busy       = (state_q == HOLD) || (state_q == ENABLE);
    assign proj_ena   = proj_ena_q;
    assign proj_rst_n = proj_rst_n_q;
    assign active_idx = active_idx_q;
    assign sel_err    = sel_err_q;

endmodule
